// File: rtl/io_bus_arbiter_if.sv
// rtl/io_bus_arbiter_if.sv - request/response bus bundle shared by masters and the slave
// The master modport is the side that issues addr/wdata/read/write and receives rdata/ack.
interface io_bus_arbiter_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        read;
  logic        write;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output addr,
    output wdata,
    output read,
    output write,
    input  rdata,
    input  ack
  );

  modport slave (
    input  addr,
    input  wdata,
    input  read,
    input  write,
    output rdata,
    output ack
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-master round-robin IO bus arbiter with per-transaction watchdog
// The grant is held until the slave acks, the owner aborts, or the watchdog forces an error ack.
module io_bus_arbiter #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                rst,
  io_bus_arbiter_if.slave     m0,
  io_bus_arbiter_if.slave     m1,
  io_bus_arbiter_if.master    s,
  input  logic                err_clr,
  output logic                bus_err,
  output logic [31:0]         err_addr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic          owner, owner_nx;
  logic          last, last_nx;
  logic [CW-1:0] tcnt, tcnt_nx;
  logic          bus_err_q, bus_err_nx;
  logic [31:0]   err_addr_q, err_addr_nx;

  logic          req0, req1, grant;
  logic [31:0]   own_addr, own_wdata;
  logic          own_read, own_write, own_req;
  logic          active, timeout_hit, done_ack;
  logic [31:0]   ack_data;

  always_comb begin
    req0      = m0.read | m0.write;
    req1      = m1.read | m1.write;
    // Tie goes to whoever was not served last; a lone requester always wins.
    grant     = (req0 && req1) ? ~last : req1;
    own_addr  = owner ? m1.addr  : m0.addr;
    own_wdata = owner ? m1.wdata : m0.wdata;
    own_read  = owner ? m1.read  : m0.read;
    own_write = owner ? m1.write : m0.write;
    own_req   = own_read | own_write;
    active      = (state == BUSY) && own_req && !rst;
    timeout_hit = active && !s.ack && (tcnt == CW'(TIMEOUT - 1));
    done_ack    = active && (s.ack || timeout_hit);
    ack_data    = s.ack ? s.rdata : ERR_DATA;
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    last_nx     = last;
    tcnt_nx     = tcnt;
    bus_err_nx  = bus_err_q;
    err_addr_nx = err_addr_q;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nx = BUSY;
          owner_nx = grant;
          last_nx  = grant;
          tcnt_nx  = '0;
        end
      end
      BUSY: begin
        if (!own_req || done_ack) begin
          state_nx = IDLE;
          tcnt_nx  = '0;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A timeout in the same cycle as err_clr must leave the flag set.
    if (timeout_hit) begin
      bus_err_nx  = 1'b1;
      err_addr_nx = own_addr;
    end else if (err_clr) begin
      bus_err_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last       <= 1'b1;
      tcnt       <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last       <= last_nx;
      tcnt       <= tcnt_nx;
      bus_err_q  <= bus_err_nx;
      err_addr_q <= err_addr_nx;
    end
  end

  always_comb begin
    s.addr   = '0;
    s.wdata  = '0;
    s.read   = 1'b0;
    s.write  = 1'b0;
    m0.ack   = 1'b0;
    m0.rdata = '0;
    m1.ack   = 1'b0;
    m1.rdata = '0;
    if (active) begin
      s.addr  = own_addr;
      s.wdata = own_wdata;
      // Read+write together is a write; strobes drop in the watchdog cycle.
      s.write = own_write && !timeout_hit;
      s.read  = own_read && !own_write && !timeout_hit;
    end
    if (done_ack) begin
      if (owner) begin
        m1.ack   = 1'b1;
        m1.rdata = ack_data;
      end else begin
        m0.ack   = 1'b1;
        m0.rdata = ack_data;
      end
    end
  end

  assign bus_err  = bus_err_q && !rst;
  assign err_addr = rst ? 32'h0 : err_addr_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - directed scenarios plus randomized traffic against a transaction model
module tb_io_bus_arbiter;
  localparam int          TIMEOUT  = 64;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_clr = 1'b0;
  logic        bus_err;
  logic [31:0] err_addr;
  int          n_checks = 0;
  int          n_fail = 0;

  io_bus_arbiter_if m0_bus();
  io_bus_arbiter_if m1_bus();
  io_bus_arbiter_if s_bus();

  io_bus_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus),
    .err_clr(err_clr), .bus_err(bus_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_bus.addr = 0; m0_bus.wdata = 0; m0_bus.read = 0; m0_bus.write = 0;
    m1_bus.addr = 0; m1_bus.wdata = 0; m1_bus.read = 0; m1_bus.write = 0;
    s_bus.ack = 0; s_bus.rdata = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    logic [67:0] got;
    idle_inputs();
    rst = 1;
    m0_bus.read = 1; m0_bus.addr = 32'h10;
    tick(); tick();
    @(negedge clk);
    got = {m0_bus.ack, m1_bus.ack, s_bus.read, s_bus.write, bus_err, err_addr, s_bus.addr[30:0]};
    n_checks++;
    if (got !== 68'h0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", got); end
    m0_bus.read = 0;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_single_read();
    logic [35:0] g1;
    logic [66:0] g2;
    logic [1:0]  g3;
    do_reset();
    m0_bus.addr = 32'h10; m0_bus.read = 1;
    @(negedge clk);
    n_checks++;
    if (s_bus.read !== 1'b0) begin n_fail++; $display("FAIL read_arb_cycle s_read=%b exp=0", s_bus.read); end
    tick();
    @(negedge clk);
    g1 = {s_bus.read, s_bus.addr, m0_bus.ack, m1_bus.ack, 1'b0};
    n_checks++;
    if (g1 !== {1'b1, 32'h10, 3'b000}) begin n_fail++; $display("FAIL read_busy1 got=%h exp=%h", g1, {1'b1, 32'h10, 3'b000}); end
    tick();
    s_bus.ack = 1; s_bus.rdata = 32'h12345678;
    @(negedge clk);
    g2 = {s_bus.read, m0_bus.ack, m0_bus.rdata, m1_bus.ack, m1_bus.rdata[31:0]} ;
    n_checks++;
    if (g2 !== {1'b1, 1'b1, 32'h12345678, 1'b0, 32'h0}) begin n_fail++; $display("FAIL read_ack got=%h", g2); end
    tick();
    s_bus.ack = 0; m0_bus.read = 0;
    @(negedge clk);
    g3 = {s_bus.read, m0_bus.ack};
    n_checks++;
    if (g3 !== 2'b00) begin n_fail++; $display("FAIL read_after_ack got=%b exp=00", g3); end
    tick();
  endtask

  task automatic test_tie();
    logic [5:0] a0, a1;
    do_reset();
    s_bus.ack = 1; s_bus.rdata = 32'hA0;
    m0_bus.addr = 32'h11; m0_bus.read = 1;
    m1_bus.addr = 32'h22; m1_bus.read = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a0[i] = m0_bus.ack;
      a1[i] = m1_bus.ack;
      tick();
    end
    n_checks++;
    if ({a0, a1} !== {6'b100010, 6'b001000}) begin
      n_fail++; $display("FAIL tie_alternate m0=%b m1=%b exp m0=100010 m1=001000", a0, a1);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    int          ack_at = -1;
    int          wr_cycles = 0;
    logic [31:0] got_rdata = 0;
    logic        got_sw = 1;
    m1_bus.addr = 32'h20; m1_bus.wdata = 32'hA5; m1_bus.write = 1;
    @(negedge clk);
    tick();
    for (int c = 1; c <= TIMEOUT + 4 && ack_at < 0; c++) begin
      @(negedge clk);
      if (m1_bus.ack) begin
        ack_at = c; got_rdata = m1_bus.rdata; got_sw = s_bus.write;
      end else if (s_bus.write) begin
        wr_cycles++;
      end
      tick();
    end
    m1_bus.write = 0;
    n_checks++;
    if (ack_at !== TIMEOUT) begin n_fail++; $display("FAIL timeout_cycle got=%0d exp=%0d", ack_at, TIMEOUT); end
    n_checks++;
    if ({got_rdata, got_sw} !== {ERR_DATA, 1'b0}) begin n_fail++; $display("FAIL timeout_ack rdata=%h s_write=%b", got_rdata, got_sw); end
    n_checks++;
    if (wr_cycles !== TIMEOUT - 1) begin n_fail++; $display("FAIL timeout_strobe got=%0d exp=%0d", wr_cycles, TIMEOUT - 1); end
    @(negedge clk);
    n_checks++;
    if ({bus_err, err_addr} !== {1'b1, 32'h20}) begin n_fail++; $display("FAIL timeout_err got=%b/%h exp=1/20", bus_err, err_addr); end
    tick();
    err_clr = 1;
    tick();
    err_clr = 0;
    @(negedge clk);
    n_checks++;
    if ({bus_err, err_addr} !== {1'b0, 32'h20}) begin n_fail++; $display("FAIL err_clr got=%b/%h exp=0/20", bus_err, err_addr); end
    tick();
  endtask

  task automatic test_rw();
    logic [65:0] got;
    m0_bus.addr = 32'h04; m0_bus.wdata = 32'hCAFE0004; m0_bus.read = 1; m0_bus.write = 1;
    @(negedge clk);
    tick();
    @(negedge clk);
    got = {s_bus.write, s_bus.read, s_bus.wdata, s_bus.addr};
    n_checks++;
    if (got !== {1'b1, 1'b0, 32'hCAFE0004, 32'h04}) begin n_fail++; $display("FAIL rw_as_write got=%h", got); end
    tick();
    s_bus.ack = 1;
    @(negedge clk);
    n_checks++;
    if (m0_bus.ack !== 1'b1) begin n_fail++; $display("FAIL rw_ack got=%b exp=1", m0_bus.ack); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_abort();
    logic [35:0] g1;
    logic [1:0]  g2;
    logic [32:0] g3;
    m0_bus.addr = 32'h30; m0_bus.read = 1;
    @(negedge clk);
    tick();
    tick();
    m0_bus.read = 0;
    m1_bus.addr = 32'h31; m1_bus.read = 1;
    @(negedge clk);
    g1 = {s_bus.read, s_bus.write, s_bus.addr, m0_bus.ack, m1_bus.ack};
    n_checks++;
    if (g1 !== 36'h0) begin n_fail++; $display("FAIL abort_same_cycle got=%h exp=0", g1); end
    tick();
    @(negedge clk);
    g2 = {s_bus.read, m0_bus.ack};
    n_checks++;
    if (g2 !== 2'b00) begin n_fail++; $display("FAIL abort_idle got=%b exp=00", g2); end
    tick();
    @(negedge clk);
    g3 = {s_bus.read, s_bus.addr};
    n_checks++;
    if (g3 !== {1'b1, 32'h31}) begin n_fail++; $display("FAIL abort_next_grant got=%h exp=%h", g3, {1'b1, 32'h31}); end
    tick();
    s_bus.ack = 1;
    @(negedge clk);
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_rst_mid();
    logic [67:0] g1;
    logic [2:0]  g2;
    logic [65:0] g3;
    m0_bus.addr = 32'h40; m0_bus.read = 1;
    @(negedge clk);
    tick();
    tick();
    rst = 1;
    @(negedge clk);
    g1 = {m0_bus.ack, m1_bus.ack, s_bus.read, s_bus.addr, bus_err, err_addr[31:1]};
    n_checks++;
    if (g1 !== 68'h0) begin n_fail++; $display("FAIL rst_mid_outputs got=%h exp=0", g1); end
    tick();
    rst = 0; s_bus.ack = 1; s_bus.rdata = 32'h55; m0_bus.read = 0;
    @(negedge clk);
    g2 = {m0_bus.ack, m1_bus.ack, s_bus.read};
    n_checks++;
    if (g2 !== 3'b000) begin n_fail++; $display("FAIL late_ack_ignored got=%b exp=000", g2); end
    tick();
    s_bus.ack = 0;
    m0_bus.addr = 32'h41; m0_bus.read = 1;
    m1_bus.addr = 32'h42; m1_bus.read = 1;
    @(negedge clk);
    tick();
    @(negedge clk);
    g3 = {s_bus.read, bus_err, s_bus.addr, err_addr[31:0]};
    n_checks++;
    if (g3 !== {1'b1, 1'b0, 32'h41, 32'h0}) begin n_fail++; $display("FAIL rst_first_tie got=%h exp=%h", g3, {1'b1, 1'b0, 32'h41, 32'h0}); end
    tick();
    s_bus.ack = 1;
    @(negedge clk);
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ma[2], mw[2];
    bit          mr[2], mwr[2], drop[2];
    bit          m_busy = 0, m_err = 0, dead = 0;
    int          m_owner = 0, m_last = 1, m_age = 0, own = 0, k;
    logic [31:0] m_err_addr = 0;
    bit          e_ack[2], tmo, req_o;
    logic [31:0] e_rd[2], e_sa, e_sw;
    bit          e_srd, e_swr;
    logic [164:0] exp_v, got_v;
    int          fails_before = n_fail;
    int          timeouts = 0;
    do_reset();
    for (int i = 0; i < 2; i++) begin ma[i] = 0; mw[i] = 0; mr[i] = 0; mwr[i] = 0; drop[i] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (drop[i]) begin
          mr[i] = 0; mwr[i] = 0; drop[i] = 0;
        end else if (!(mr[i] || mwr[i])) begin
          if ($urandom % 3 == 0) begin
            ma[i] = $urandom % 256; mw[i] = $urandom; k = $urandom % 3;
            mr[i] = (k != 1); mwr[i] = (k != 0);
          end
        end else if ($urandom % 200 == 0) begin
          mr[i] = 0; mwr[i] = 0;
        end
      end
      m0_bus.addr = ma[0]; m0_bus.wdata = mw[0]; m0_bus.read = mr[0]; m0_bus.write = mwr[0];
      m1_bus.addr = ma[1]; m1_bus.wdata = mw[1]; m1_bus.read = mr[1]; m1_bus.write = mwr[1];
      if (cyc % 400 == 0) dead = ($urandom % 2) == 1;
      s_bus.ack = !dead && ($urandom % 3 == 0);
      s_bus.rdata = $urandom;
      err_clr = ($urandom % 16 == 0);
      @(negedge clk);
      e_ack[0] = 0; e_ack[1] = 0; e_rd[0] = 0; e_rd[1] = 0;
      e_sa = 0; e_sw = 0; e_srd = 0; e_swr = 0; tmo = 0; req_o = 0;
      if (m_busy) begin
        own = m_owner;
        req_o = mr[own] || mwr[own];
        if (req_o) begin
          tmo = (m_age == TIMEOUT - 1) && !s_bus.ack;
          e_sa = ma[own]; e_sw = mw[own];
          e_swr = mwr[own] && !tmo;
          e_srd = mr[own] && !mwr[own] && !tmo;
          if (s_bus.ack || tmo) begin
            e_ack[own] = 1;
            e_rd[own] = s_bus.ack ? s_bus.rdata : ERR_DATA;
          end
        end
      end
      exp_v = {e_ack[0], e_rd[0], e_ack[1], e_rd[1], e_sa, e_sw, e_srd, e_swr, m_err, m_err_addr};
      got_v = {m0_bus.ack, m0_bus.rdata, m1_bus.ack, m1_bus.rdata, s_bus.addr, s_bus.wdata,
               s_bus.read, s_bus.write, bus_err, err_addr};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        if (n_fail - fails_before < 10) $display("FAIL random_cycle%0d got=%h exp=%h", cyc, got_v, exp_v);
      end
      drop[0] = e_ack[0]; drop[1] = e_ack[1];
      if (tmo) begin
        m_err = 1; m_err_addr = ma[own]; timeouts++;
      end else if (err_clr) begin
        m_err = 0;
      end
      if (m_busy) begin
        if (!req_o || e_ack[own]) m_busy = 0;
        else m_age++;
      end else if (mr[0] || mwr[0] || mr[1] || mwr[1]) begin
        if ((mr[0] || mwr[0]) && (mr[1] || mwr[1])) m_owner = 1 - m_last;
        else m_owner = (mr[1] || mwr[1]) ? 1 : 0;
        m_last = m_owner; m_busy = 1; m_age = 0;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_timeout();
    test_rw();
    test_abort();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
